// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
package hazard_ctrl_pkg;

    localparam int unsigned CNT_W      = 2;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned STATS_W    = 32;

    typedef logic [1:0]       state_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam state_t ST_RUN    = 2'd0;
    localparam state_t ST_LSTALL = 2'd1;
    localparam state_t ST_FLUSH  = 2'd2;
    localparam state_t ST_MWAIT  = 2'd3;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Counter value loaded when a multi-cycle stall/flush starts: cycles beyond the first, minus one.
    function automatic cnt_t reload_val(input int unsigned cycles);
        return (cycles > 1) ? cnt_t'(cycles - 2) : '0;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller: master is the pipeline, slave the controller.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] Rreg_addr1;
    logic [REG_ADDR_W-1:0] Rreg_addr2;
    logic                  uses_rt;
    logic                  MemRead2_3;
    logic [REG_ADDR_W-1:0] Wreg_addr2_3;
    logic                  br_taken;
    logic                  JtoPC2_3;
    logic                  mem_busy;

    logic                  PCWrite;
    logic                  IF_ID_Write;
    logic                  IF_ID_Flush;
    logic                  ID_EX_Write;
    logic                  ID_EX_Bubble;
    logic                  EX_MEM_Write;

    modport master (
        output Rreg_addr1, Rreg_addr2, uses_rt, MemRead2_3, Wreg_addr2_3,
               br_taken, JtoPC2_3, mem_busy,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Write
    );

    modport slave (
        input  Rreg_addr1, Rreg_addr2, uses_rt, MemRead2_3, Wreg_addr2_3,
               br_taken, JtoPC2_3, mem_busy,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Write
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between the EX-stage load and the ID-stage sources.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic                  i_mem_read,
    input  logic [REG_ADDR_W-1:0] i_wreg,
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [REG_ADDR_W-1:0] i_rt,
    input  logic                  i_uses_rt,
    output logic                  o_hazard
);

    // $0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign o_hazard = i_mem_read && (i_wreg != REG_ZERO) &&
                      ((i_wreg == i_rs) || (i_uses_rt && (i_wreg == i_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline; state advances on the falling clock edge.
// Optional HAZARD_STATS_EN adds saturating stall/flush/freeze event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES      = 1
) (
    input  logic               CLK,
    input  logic               RST,
    hazard_ctrl_if.slave       hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [STATS_W-1:0] stall_cnt,
    output logic [STATS_W-1:0] flush_cnt,
    output logic [STATS_W-1:0] freeze_cnt
`endif
);

    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 3) begin : g_bad_ls
        $error("LOAD_STALL_CYCLES must be within 1..3");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_bad_fc
        $error("FLUSH_CYCLES must be within 1..3");
    end

    localparam cnt_t LS_RELOAD = reload_val(LOAD_STALL_CYCLES);
    localparam cnt_t FC_RELOAD = reload_val(FLUSH_CYCLES);

    state_t r_state, w_state_nx;
    state_t r_saved_state, w_saved_state_nx;
    cnt_t   r_cnt, w_cnt_nx;
    cnt_t   r_saved_cnt, w_saved_cnt_nx;

    logic w_load_use;
    logic w_flush_ev;
    logic w_stall_act;
    logic w_flush_acc;
    logic w_pc_write, w_ifid_write, w_ifid_flush, w_idex_write, w_idex_bubble, w_exmem_write;

    hazard_detect u_detect (
        .i_mem_read (hz.MemRead2_3),
        .i_wreg     (hz.Wreg_addr2_3),
        .i_rs       (hz.Rreg_addr1),
        .i_rt       (hz.Rreg_addr2),
        .i_uses_rt  (hz.uses_rt),
        .o_hazard   (w_load_use)
    );

    assign w_flush_ev = hz.br_taken | hz.JtoPC2_3;

    always_comb begin
        w_pc_write       = 1'b1;
        w_ifid_write     = 1'b1;
        w_ifid_flush     = 1'b0;
        w_idex_write     = 1'b1;
        w_idex_bubble    = 1'b0;
        w_exmem_write    = 1'b1;
        w_stall_act      = 1'b0;
        w_flush_acc      = 1'b0;
        w_state_nx       = r_state;
        w_cnt_nx         = r_cnt;
        w_saved_state_nx = r_saved_state;
        w_saved_cnt_nx   = r_saved_cnt;

        if (hz.mem_busy) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_write  = 1'b0;
            w_exmem_write = 1'b0;
            w_state_nx    = ST_MWAIT;
            if (r_state != ST_MWAIT) begin
                w_saved_state_nx = r_state;
                w_saved_cnt_nx   = r_cnt;
            end
        end else if (r_state == ST_LSTALL && !w_flush_ev) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            w_stall_act   = 1'b1;
            w_state_nx    = (r_cnt == '0) ? ST_RUN : ST_LSTALL;
            w_cnt_nx      = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
        end else if (r_state == ST_FLUSH) begin
            w_ifid_flush = 1'b1;
            if (w_flush_ev) begin
                w_idex_bubble = 1'b1;
                w_flush_acc   = 1'b1;
                w_cnt_nx      = FC_RELOAD;
            end else begin
                w_state_nx = (r_cnt == '0) ? ST_RUN : ST_FLUSH;
                w_cnt_nx   = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
            end
        end else begin
            // RUN, MWAIT exit, or a flush that kills an in-progress load-use stall.
            w_state_nx = ST_RUN;
            w_cnt_nx   = '0;
            if (w_flush_ev) begin
                w_ifid_flush  = 1'b1;
                w_idex_bubble = 1'b1;
                w_flush_acc   = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    w_state_nx = ST_FLUSH;
                    w_cnt_nx   = FC_RELOAD;
                end
            end else begin
                if (w_load_use) begin
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_bubble = 1'b1;
                    w_stall_act   = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        w_state_nx = ST_LSTALL;
                        w_cnt_nx   = LS_RELOAD;
                    end
                end
                if (r_state == ST_MWAIT && r_saved_state != ST_RUN) begin
                    w_state_nx = r_saved_state;
                    w_cnt_nx   = r_saved_cnt;
                end
            end
        end

        if (RST) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_write  = 1'b0;
            w_idex_bubble = 1'b1;
            w_exmem_write = 1'b0;
        end
    end

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= ST_RUN;
            r_cnt         <= '0;
            r_saved_state <= ST_RUN;
            r_saved_cnt   <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_saved_state <= w_saved_state_nx;
            r_saved_cnt   <= w_saved_cnt_nx;
        end
    end

    assign hz.PCWrite      = w_pc_write;
    assign hz.IF_ID_Write  = w_ifid_write;
    assign hz.IF_ID_Flush  = w_ifid_flush;
    assign hz.ID_EX_Write  = w_idex_write;
    assign hz.ID_EX_Bubble = w_idex_bubble;
    assign hz.EX_MEM_Write = w_exmem_write;

`ifdef HAZARD_STATS_EN
    logic [STATS_W-1:0] r_stall_cnt, r_flush_cnt, r_freeze_cnt;

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            if (w_stall_act && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_acc && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
            if (r_state == ST_MWAIT && r_freeze_cnt != '1) r_freeze_cnt <= r_freeze_cnt + 1'b1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign freeze_cnt = r_freeze_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: three controller configurations share one randomized stimulus stream.
module tb_hazard_ctrl;

    localparam logic [5:0] E_NORMAL = 6'b110101;
    localparam logic [5:0] E_RESET  = 6'b001010;
    localparam logic [5:0] E_STALL  = 6'b000111;
    localparam logic [5:0] E_FLUSHB = 6'b111111;
    localparam logic [5:0] E_FLUSH  = 6'b111101;
    localparam logic [5:0] E_FREEZE = 6'b000000;

    localparam int LS [3] = '{1, 2, 3};
    localparam int FC [3] = '{1, 2, 3};

    logic       CLK = 1'b0;
    logic       rst, busy, br, jmp, mr, ur;
    logic [4:0] wr, rs, rt;

    always #5 CLK = ~CLK;

    hazard_ctrl_if ifa ();
    hazard_ctrl_if ifb ();
    hazard_ctrl_if ifc ();

    assign ifa.Rreg_addr1 = rs;   assign ifb.Rreg_addr1 = rs;   assign ifc.Rreg_addr1 = rs;
    assign ifa.Rreg_addr2 = rt;   assign ifb.Rreg_addr2 = rt;   assign ifc.Rreg_addr2 = rt;
    assign ifa.uses_rt = ur;      assign ifb.uses_rt = ur;      assign ifc.uses_rt = ur;
    assign ifa.MemRead2_3 = mr;   assign ifb.MemRead2_3 = mr;   assign ifc.MemRead2_3 = mr;
    assign ifa.Wreg_addr2_3 = wr; assign ifb.Wreg_addr2_3 = wr; assign ifc.Wreg_addr2_3 = wr;
    assign ifa.br_taken = br;     assign ifb.br_taken = br;     assign ifc.br_taken = br;
    assign ifa.JtoPC2_3 = jmp;    assign ifb.JtoPC2_3 = jmp;    assign ifc.JtoPC2_3 = jmp;
    assign ifa.mem_busy = busy;   assign ifb.mem_busy = busy;   assign ifc.mem_busy = busy;

`ifdef HAZARD_STATS_EN
    logic [31:0] s_stall [3];
    logic [31:0] s_flush [3];
    logic [31:0] s_freeze [3];
`endif

    hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1)) dut_a (
        .CLK(CLK), .RST(rst), .hz(ifa)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(s_stall[0]), .flush_cnt(s_flush[0]), .freeze_cnt(s_freeze[0])
`endif
    );
    hazard_ctrl #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(2)) dut_b (
        .CLK(CLK), .RST(rst), .hz(ifb)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(s_stall[1]), .flush_cnt(s_flush[1]), .freeze_cnt(s_freeze[1])
`endif
    );
    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(3)) dut_c (
        .CLK(CLK), .RST(rst), .hz(ifc)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(s_stall[2]), .flush_cnt(s_flush[2]), .freeze_cnt(s_freeze[2])
`endif
    );

    logic [5:0] act [3];
    assign act[0] = {ifa.PCWrite, ifa.IF_ID_Write, ifa.IF_ID_Flush,
                     ifa.ID_EX_Write, ifa.ID_EX_Bubble, ifa.EX_MEM_Write};
    assign act[1] = {ifb.PCWrite, ifb.IF_ID_Write, ifb.IF_ID_Flush,
                     ifb.ID_EX_Write, ifb.ID_EX_Bubble, ifb.EX_MEM_Write};
    assign act[2] = {ifc.PCWrite, ifc.IF_ID_Write, ifc.IF_ID_Flush,
                     ifc.ID_EX_Write, ifc.ID_EX_Bubble, ifc.EX_MEM_Write};

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    logic [17:0] exp_q [$];

    // Reference model: cycles of stall/flush still owed, and what was owed when memory froze us.
    int stall_rem [3], flush_rem [3], pend_stall [3], pend_flush [3];
    bit waiting [3];
    int m_stall [3], m_flush [3], m_freeze [3];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s cycle %0d: got %b required %b", name, cycle, got, want);
    endtask

    task automatic flush_action(input int k, output logic [5:0] e);
        e = E_FLUSHB;
        m_flush[k]++;
        stall_rem[k] = 0;
        flush_rem[k] = FC[k] - 1;
    endtask

    task automatic model_cycle(input int k, output logic [5:0] e);
        bit fev, lu, was;
        fev = br | jmp;
        lu  = mr && (wr != 5'd0) && (wr == rs || (ur && wr == rt));
        if (rst) begin
            e = E_RESET;
            stall_rem[k] = 0; flush_rem[k] = 0; pend_stall[k] = 0; pend_flush[k] = 0;
            waiting[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_freeze[k] = 0;
        end else begin
            if (waiting[k]) m_freeze[k]++;
            if (busy) begin
                e = E_FREEZE;
                if (!waiting[k]) begin
                    pend_stall[k] = stall_rem[k];
                    pend_flush[k] = flush_rem[k];
                    stall_rem[k]  = 0;
                    flush_rem[k]  = 0;
                    waiting[k]    = 1;
                end
            end else begin
                was = waiting[k];
                waiting[k] = 0;
                if (stall_rem[k] > 0) begin
                    if (fev) flush_action(k, e);
                    else begin e = E_STALL; m_stall[k]++; stall_rem[k]--; end
                end else if (flush_rem[k] > 0) begin
                    if (fev) begin e = E_FLUSHB; m_flush[k]++; flush_rem[k] = FC[k] - 1; end
                    else begin e = E_FLUSH; flush_rem[k]--; end
                end else begin
                    if (fev) flush_action(k, e);
                    else if (lu) begin e = E_STALL; m_stall[k]++; stall_rem[k] = LS[k] - 1; end
                    else e = E_NORMAL;
                    if (was && !fev) begin
                        if (pend_stall[k] > 0) begin
                            stall_rem[k] = pend_stall[k];
                        end else if (pend_flush[k] > 0) begin
                            flush_rem[k] = pend_flush[k];
                            stall_rem[k] = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic b, input logic bt, input logic j,
                         input logic m, input logic u, input logic [4:0] w,
                         input logic [4:0] s1, input logic [4:0] s2);
        logic [5:0] e0, e1, e2;
        @(negedge CLK);
        #1;
        rst = r; busy = b; br = bt; jmp = j; mr = m; ur = u; wr = w; rs = s1; rt = s2;
        model_cycle(0, e0);
        model_cycle(1, e1);
        model_cycle(2, e2);
        exp_q.push_back({e0, e1, e2});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2);
    endtask

    // Monitor: outputs are Mealy and valid every cycle, so compare at each rising edge.
    initial begin
        logic [17:0] e;
        forever begin
            @(posedge CLK);
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_ls1_fc1", {26'd0, act[0]}, {26'd0, e[17:12]});
                check("out_ls2_fc2", {26'd0, act[1]}, {26'd0, e[11:6]});
                check("out_ls3_fc3", {26'd0, act[2]}, {26'd0, e[5:0]});
            end
        end
    end

    initial begin
        rst = 1; busy = 0; br = 0; jmp = 0; mr = 0; ur = 0; wr = 0; rs = 0; rt = 0;
        drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle(2);
        // Load-use via rs, then the $0 and uses_rt=0 non-hazards.
        drive(0, 0, 0, 0, 1, 0, 5'd8, 5'd8, 5'd3);
        idle(4);
        drive(0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0);
        drive(0, 0, 0, 0, 1, 0, 5'd9, 5'd1, 5'd9);
        drive(0, 0, 0, 0, 1, 1, 5'd9, 5'd1, 5'd9);
        idle(4);
        // Taken branch, then branch coincident with a load-use hazard.
        drive(0, 0, 1, 0, 0, 0, 5'd0, 5'd1, 5'd2);
        idle(4);
        drive(0, 0, 1, 0, 1, 0, 5'd8, 5'd8, 5'd2);
        idle(4);
        // Memory wait arriving during a multi-cycle load-use stall.
        drive(0, 0, 0, 0, 1, 0, 5'd8, 5'd8, 5'd2);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2);
        idle(5);
        // Reset asserted mid-flush.
        drive(0, 0, 0, 1, 0, 0, 5'd0, 5'd1, 5'd2);
        drive(1, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2);
        idle(3);
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 12),
                  ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 4),
                  ($urandom_range(0, 99) < 50), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)));
        end
        // Counters settle on the falling edge that ends the last modelled cycle.
        @(negedge CLK);
        #1;
`ifdef HAZARD_STATS_EN
        for (int k = 0; k < 3; k++) begin
            check("stall_cnt", s_stall[k], 32'(m_stall[k]));
            check("flush_cnt", s_flush[k], 32'(m_flush[k]));
            check("freeze_cnt", s_freeze[k], 32'(m_freeze[k]));
        end
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
